// File: rtl/ram_pkg.sv
// Shared types for the dual-port byte-enable RAM: read-during-write policy
// and init sequencer states.
package ram_pkg;

  typedef enum logic [1:0] {
    RM_WRITE_FIRST = 2'd0,
    RM_READ_FIRST  = 2'd1,
    RM_NO_CHANGE   = 2'd2
  } read_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } init_state_e;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/ram_dp_be_if.sv
// Two-port access bundle for ram_dp_be: per-port request/result signals plus
// the init-done indication. The master drives requests, the slave is the RAM.
interface ram_dp_be_if #(
  parameter int DEPTH      = 2**16,
  parameter int DATA_WIDTH = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_WIDTH / 8;

  logic                  i_en_a;
  logic [AW-1:0]         i_addr_a;
  logic [DATA_WIDTH-1:0] i_data_a;
  logic [NB-1:0]         i_be_a;
  logic [DATA_WIDTH-1:0] o_data_a;
  logic                  o_valid_a;

  logic                  i_en_b;
  logic [AW-1:0]         i_addr_b;
  logic [DATA_WIDTH-1:0] i_data_b;
  logic [NB-1:0]         i_be_b;
  logic [DATA_WIDTH-1:0] o_data_b;
  logic                  o_valid_b;

  logic                  o_init_done;

  modport master (
    output i_en_a, i_addr_a, i_data_a, i_be_a,
    output i_en_b, i_addr_b, i_data_b, i_be_b,
    input  o_data_a, o_valid_a, o_data_b, o_valid_b, o_init_done
  );

  modport slave (
    input  i_en_a, i_addr_a, i_data_a, i_be_a,
    input  i_en_b, i_addr_b, i_data_b, i_be_b,
    output o_data_a, o_valid_a, o_data_b, o_valid_b, o_init_done
  );

endinterface

// File: rtl/ram_port_pipe.sv
// Per-port result path: optional extra pipeline stage, then the output
// register that pulses o_valid and holds o_data between results.
module ram_port_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter bit OUT_REG    = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_acc,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_word,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  logic                  fin_valid_s;
  logic                  fin_load_s;
  logic [DATA_WIDTH-1:0] fin_word_s;
  logic                  valid_r;
  logic [DATA_WIDTH-1:0] data_r;

  if (OUT_REG) begin : g_stage
    logic                  stg_valid_r;
    logic                  stg_load_r;
    logic [DATA_WIDTH-1:0] stg_word_r;

    // Extra pipeline stage between array read and output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        stg_valid_r <= 1'b0;
        stg_load_r  <= 1'b0;
        stg_word_r  <= '0;
      end else begin
        stg_valid_r <= i_acc;
        stg_load_r  <= i_load;
        stg_word_r  <= i_word;
      end
    end

    assign fin_valid_s = stg_valid_r;
    assign fin_load_s  = stg_load_r;
    assign fin_word_s  = stg_word_r;
  end else begin : g_direct
    assign fin_valid_s = i_acc;
    assign fin_load_s  = i_load;
    assign fin_word_s  = i_word;
  end

  // Output register: valid pulses once per access, data only moves on a load
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else begin
      valid_r <= fin_valid_s;
      if (fin_valid_s && fin_load_s) begin
        data_r <= fin_word_s;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign o_valid = valid_r;
  assign o_data  = data_r;

endmodule

// File: rtl/ram_dp_be.sv
// True dual-port RAM with byte enables, configurable read-during-write policy,
// optional output register and a post-reset zero-fill sequencer.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int         DEPTH          = 2**16,
  parameter int         DATA_WIDTH     = 32,
  parameter read_mode_e READ_MODE      = RM_WRITE_FIRST,
  parameter bit         OUT_REG        = 1'b0,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  ram_dp_be_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_WIDTH / BYTE_W;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam init_state_e RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  init_state_e           state_r;
  init_state_e           state_nxt_s;
  logic [CW-1:0]         cnt_r;
  logic [CW-1:0]         cnt_nxt_s;
  logic                  init_done_r;
  logic                  clr_we_s;
  logic [AW-1:0]         clr_addr_s;

  logic                  acc_a_s;
  logic                  acc_b_s;
  logic                  same_addr_s;
  logic [NB-1:0]         lane_a_s;
  logic [NB-1:0]         lane_b_s;
  logic                  wr_a_s;
  logic                  wr_b_s;
  logic [DATA_WIDTH-1:0] old_a_s;
  logic [DATA_WIDTH-1:0] old_b_s;
  logic [DATA_WIDTH-1:0] post_a_s;
  logic [DATA_WIDTH-1:0] post_b_s;
  logic [DATA_WIDTH-1:0] word_a_s;
  logic [DATA_WIDTH-1:0] word_b_s;
  logic                  load_a_s;
  logic                  load_b_s;

  // Init sequencer next state: walk the counter through every word once
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        cnt_nxt_s = cnt_r + CW'(1);
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = READY;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      READY: begin
        state_nxt_s = READY;
        cnt_nxt_s   = cnt_r;
      end
      default: begin
        state_nxt_s = RST_STATE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Init sequencer state, counter and registered done flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= RST_STATE;
      cnt_r       <= '0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      init_done_r <= (state_nxt_s == READY);
    end
  end

  assign clr_we_s   = (state_r == CLEAR);
  assign clr_addr_s = cnt_r[AW-1:0];

  // Acceptance and per-lane write enables; A owns any lane both ports hit
  always_comb begin
    acc_a_s     = bus.i_en_a & init_done_r;
    acc_b_s     = bus.i_en_b & init_done_r;
    same_addr_s = (bus.i_addr_a == bus.i_addr_b);
    lane_a_s    = {NB{acc_a_s}} & bus.i_be_a;
    lane_b_s    = {NB{acc_b_s}} & bus.i_be_b & ~({NB{same_addr_s}} & lane_a_s);
    wr_a_s      = |lane_a_s;
    wr_b_s      = |lane_b_s;
  end

  // Pre-write words and the merged post-write word seen at each port address
  always_comb begin
    old_a_s  = mem_r[bus.i_addr_a];
    old_b_s  = mem_r[bus.i_addr_b];
    post_a_s = old_a_s;
    post_b_s = old_b_s;
    for (int k = 0; k < NB; k++) begin
      if (lane_a_s[k]) begin
        post_a_s[k*BYTE_W +: BYTE_W] = bus.i_data_a[k*BYTE_W +: BYTE_W];
      end else if (lane_b_s[k] && same_addr_s) begin
        post_a_s[k*BYTE_W +: BYTE_W] = bus.i_data_b[k*BYTE_W +: BYTE_W];
      end else begin
        post_a_s[k*BYTE_W +: BYTE_W] = old_a_s[k*BYTE_W +: BYTE_W];
      end
      if (lane_b_s[k]) begin
        post_b_s[k*BYTE_W +: BYTE_W] = bus.i_data_b[k*BYTE_W +: BYTE_W];
      end else if (lane_a_s[k] && same_addr_s) begin
        post_b_s[k*BYTE_W +: BYTE_W] = bus.i_data_a[k*BYTE_W +: BYTE_W];
      end else begin
        post_b_s[k*BYTE_W +: BYTE_W] = old_b_s[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Result word per port according to the read-during-write policy
  always_comb begin
    word_a_s = old_a_s;
    word_b_s = old_b_s;
    load_a_s = 1'b1;
    load_b_s = 1'b1;
    case (READ_MODE)
      RM_WRITE_FIRST: begin
        word_a_s = post_a_s;
        word_b_s = post_b_s;
      end
      RM_READ_FIRST: begin
        word_a_s = old_a_s;
        word_b_s = old_b_s;
      end
      RM_NO_CHANGE: begin
        load_a_s = ~(|bus.i_be_a);
        load_b_s = ~(|bus.i_be_b);
      end
      default: begin
        word_a_s = old_a_s;
        word_b_s = old_b_s;
      end
    endcase
  end

  // Sole writer of the array; on a shared address both ports store the same merge
  always_ff @(posedge i_clk) begin
    if (clr_we_s) begin
      mem_r[clr_addr_s] <= '0;
    end else begin
      if (wr_a_s) begin
        mem_r[bus.i_addr_a] <= post_a_s;
      end
      if (wr_b_s) begin
        mem_r[bus.i_addr_b] <= post_b_s;
      end
    end
  end

  ram_port_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_acc   (acc_a_s),
    .i_load  (load_a_s),
    .i_word  (word_a_s),
    .o_data  (bus.o_data_a),
    .o_valid (bus.o_valid_a)
  );

  ram_port_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_acc   (acc_b_s),
    .i_load  (load_b_s),
    .i_word  (word_b_s),
    .o_data  (bus.o_data_b),
    .o_valid (bus.o_valid_b)
  );

  assign bus.o_init_done = init_done_r;

endmodule

// File: tb/tb_ram_dp_be.sv
// Scoreboard bench: three RAM instances (write-first, read-first, no-change
// with output register) share one stimulus stream; a monitor checks results.
module tb_ram_dp_be;
  import ram_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int NCH   = 6;
  localparam read_mode_e MODES [3] = '{RM_WRITE_FIRST, RM_READ_FIRST, RM_NO_CHANGE};
  localparam int LAT [NCH] = '{1, 1, 1, 1, 2, 2};

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mon_en = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [3:0]  addr_a = 4'd0, addr_b = 4'd0, be_a = 4'd0, be_b = 4'd0;
  logic [31:0] data_a = 32'd0, data_b = 32'd0;
  logic        vld [NCH];
  logic [31:0] dat [NCH];
  logic        done [3];
  logic [31:0] last_d [NCH];
  logic [31:0] cyc = 32'd0;
  exp_t        exp_q [NCH][$];
  exp_t        mon_e;
  logic        has_exp;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_dp_be_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();
    assign bus.i_en_a   = en_a;
    assign bus.i_addr_a = addr_a;
    assign bus.i_data_a = data_a;
    assign bus.i_be_a   = be_a;
    assign bus.i_en_b   = en_b;
    assign bus.i_addr_b = addr_b;
    assign bus.i_data_b = data_b;
    assign bus.i_be_b   = be_b;
    ram_dp_be #(
      .DEPTH          (DEPTH),
      .DATA_WIDTH     (DW),
      .READ_MODE      (MODES[g]),
      .OUT_REG        (g == 2),
      .CLEAR_ON_RESET (1'b1)
    ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
    );
    assign vld[2*g]   = bus.o_valid_a;
    assign dat[2*g]   = bus.o_data_a;
    assign vld[2*g+1] = bus.o_valid_b;
    assign dat[2*g+1] = bus.o_data_b;
    assign done[g]    = bus.o_init_done;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic push(input int ch, input logic [31:0] v);
    exp_q[ch].push_back('{data: v, due: cyc + 32'(LAT[ch])});
  endtask

  // Channels: 0/1 write-first a/b, 2/3 read-first a/b, 4/5 no-change a/b
  task automatic acc(input logic ea, input logic [3:0] aa, input logic [31:0] da, input logic [3:0] bea,
                     input logic eb, input logic [3:0] ab, input logic [31:0] db, input logic [3:0] beb,
                     input logic [31:0] xwa, input logic [31:0] xra, input logic [31:0] xna,
                     input logic [31:0] xwb, input logic [31:0] xrb, input logic [31:0] xnb);
    en_a = ea; addr_a = aa; data_a = da; be_a = bea;
    en_b = eb; addr_b = ab; data_b = db; be_b = beb;
    if (ea) begin push(0, xwa); push(2, xra); push(4, xna); end
    if (eb) begin push(1, xwb); push(3, xrb); push(5, xnb); end
    @(posedge clk); #1;
    en_a = 1'b0; en_b = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      exp_q[ch].delete();
      last_d[ch] = 32'd0;
    end
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      chk($sformatf("rst_data_ch%0d", ch), dat[ch], 32'd0);
      chk($sformatf("rst_valid_ch%0d", ch), {31'd0, vld[ch]}, 32'd0);
    end
    for (int g = 0; g < 3; g++) chk($sformatf("rst_done_%0d", g), {31'd0, done[g]}, 32'd0);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!(done[0] || done[1] || done[2]) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("init_cycles", 32'(n), 32'd16);
    for (int g = 0; g < 3; g++) chk($sformatf("init_done_%0d", g), {31'd0, done[g]}, 32'd1);
  endtask

  // Monitor: pop on every valid, otherwise the output must hold its value
  always @(negedge clk) begin
    if (mon_en) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (vld[ch]) begin
          has_exp = (exp_q[ch].size() != 0);
          chk($sformatf("expected_valid_ch%0d", ch), {31'd0, has_exp}, 32'd1);
          if (has_exp) begin
            mon_e = exp_q[ch].pop_front();
            chk($sformatf("data_ch%0d", ch), dat[ch], mon_e.data);
            chk($sformatf("latency_ch%0d", ch), cyc, mon_e.due);
          end
          last_d[ch] = dat[ch];
        end else begin
          chk($sformatf("hold_ch%0d", ch), dat[ch], last_d[ch]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    do_reset();
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // abort the clear sequence once it reaches address 8
    repeat (8) @(posedge clk);
    #2;
    do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();

    // every word reads zero, back-to-back on both ports
    for (int i = 0; i < DEPTH; i++)
      acc(1'b1, 4'(i), 32'd0, 4'd0, 1'b1, 4'(15 - i), 32'd0, 4'd0,
          32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    // partial byte write merges with older contents
    acc(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0, 32'd0, 4'd0,
        32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'd0, 32'd0, 32'd0);
    acc(1'b1, 4'd5, 32'h00000011, 4'h1, 1'b0, 4'd0, 32'd0, 4'd0,
        32'hDEADBE11, 32'hDEADBEEF, 32'h00000000, 32'd0, 32'd0, 32'd0);
    acc(1'b1, 4'd5, 32'd0, 4'h0, 1'b0, 4'd0, 32'd0, 4'd0,
        32'hDEADBE11, 32'hDEADBE11, 32'hDEADBE11, 32'd0, 32'd0, 32'd0);
    // disabled write is ignored
    acc(1'b0, 4'd5, 32'h00000000, 4'hF, 1'b0, 4'd0, 32'd0, 4'd0,
        32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    acc(1'b1, 4'd5, 32'd0, 4'h0, 1'b0, 4'd0, 32'd0, 4'd0,
        32'hDEADBE11, 32'hDEADBE11, 32'hDEADBE11, 32'd0, 32'd0, 32'd0);

    // same-address write collision, A wins overlapping lane 1
    acc(1'b1, 4'd3, 32'hAAAAAAAA, 4'b0011, 1'b1, 4'd3, 32'hBBBBBBBB, 4'b1110,
        32'hBBBBAAAA, 32'h00000000, 32'hDEADBE11, 32'hBBBBAAAA, 32'h00000000, 32'h00000000);
    acc(1'b1, 4'd3, 32'd0, 4'h0, 1'b1, 4'd3, 32'd0, 4'h0,
        32'hBBBBAAAA, 32'hBBBBAAAA, 32'hBBBBAAAA, 32'hBBBBAAAA, 32'hBBBBAAAA, 32'hBBBBAAAA);

    // cross-port read during write at the same address
    acc(1'b1, 4'd7, 32'h12345678, 4'hF, 1'b0, 4'd0, 32'd0, 4'd0,
        32'h12345678, 32'h00000000, 32'hBBBBAAAA, 32'd0, 32'd0, 32'd0);
    acc(1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 1'b1, 4'd7, 32'd0, 4'h0,
        32'hCAFEF00D, 32'h12345678, 32'hBBBBAAAA, 32'hCAFEF00D, 32'h12345678, 32'h12345678);
    acc(1'b1, 4'd7, 32'd0, 4'h0, 1'b1, 4'd7, 32'd0, 4'h0,
        32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);

    // reset with a read in flight: results discarded, memory re-cleared
    repeat (3) @(posedge clk);
    #1;
    en_a = 1'b1; addr_a = 4'd7; be_a = 4'h0;
    @(posedge clk); #1;
    en_a = 1'b0;
    do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    acc(1'b1, 4'd7, 32'd0, 4'h0, 1'b1, 4'd5, 32'd0, 4'h0,
        32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    repeat (4) @(posedge clk);
    #1;
    for (int ch = 0; ch < NCH; ch++)
      chk($sformatf("drain_ch%0d", ch), 32'(exp_q[ch].size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ram_dp_be.md
RAM_DP_BE -- requirements
Module: ram_dp_be

Interface
REQ-001 SHALL have parameter DEPTH, default 2**16, word count (power of two, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width (multiple of 8); NB = DATA_WIDTH/8 byte lanes.
REQ-003 SHALL have parameter READ_MODE, default RM_WRITE_FIRST, port read-during-write policy (RM_WRITE_FIRST / RM_READ_FIRST / RM_NO_CHANGE).
REQ-004 SHALL have parameter OUT_REG, default 0, 1 = extra output pipeline register per port.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, 1 = zero-fill memory after reset.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: i_clk in 1 (rising edge), then i_rst_n in 1 (async assert, active low).
REQ-007 SHALL have port o_init_done, out, 1 bit: memory accepts accesses.
REQ-008 SHALL have, per port X in {a,b}: i_en_X in 1 (access request); i_addr_X in $clog2(DEPTH); i_data_X in DATA_WIDTH; i_be_X in NB (byte write enables; all-zero = read); o_data_X out DATA_WIDTH; o_valid_X out 1 (o_data_X holds a fresh result).

Function
REQ-009 Latency SHALL be L = 1 + OUT_REG cycles: access accepted at edge n -> o_valid_X high, result on o_data_X, after edge n+L-1 for exactly one cycle per access.
REQ-010 An access SHALL be accepted only when i_en_X=1 and o_init_done=1; otherwise ignored, no memory change, o_valid_X=0 for that slot.
REQ-011 Write SHALL update only lanes with i_be_X[k]=1; other lanes keep prior contents.
REQ-012 o_data_X SHALL hold its last value when no access completes (o_valid_X=0).
REQ-013 RM_WRITE_FIRST: write result = merged new word (new enabled lanes, old other lanes). RM_READ_FIRST: result = pre-write word. RM_NO_CHANGE: o_data_X unchanged, o_valid_X still pulses.
REQ-014 Pure read (i_be_X=0) SHALL return the word at i_addr_X as of before the current edge's writes, except REQ-016.
REQ-015 Same-address write collision: per lane, A wins where i_be_a[k]=1; B's lane written where i_be_b[k]=1 and i_be_a[k]=0; stored word = merge.
REQ-016 Cross-port read-during-write, same address: reading port SHALL get the merged post-write word in RM_WRITE_FIRST, the pre-write word otherwise.
REQ-017 Writing port in a collision SHALL report the final merged stored word under RM_WRITE_FIRST.
REQ-018 Init FSM states: CLEAR, READY. Reset -> CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-019 CLEAR: zero one word per cycle at counter 0..DEPTH-1, o_init_done=0; after writing DEPTH-1 -> READY (exactly DEPTH cycles after reset release).
REQ-020 READY: o_init_done=1; terminal until reset.
REQ-021 Clear counter SHALL be $clog2(DEPTH)+1 bits; no wrap before transition.

Reset
REQ-022 While i_rst_n=0: o_data_a/b=0, o_valid_a/b=0, pipeline registers cleared, o_init_done=0, counter=0.
REQ-023 Reset mid-CLEAR or mid-access SHALL abort immediately; in-flight results discarded; CLEAR restarts from address 0.
REQ-024 Memory array SHALL NOT be reset directly; contents persist when CLEAR_ON_RESET=0.
REQ-025 Reset release SHALL be synchronous to i_clk; first legal access is on the edge at which o_init_done is first sampled 1.

Structure
REQ-026 Package ram_pkg SHALL hold read_mode_e (RM_WRITE_FIRST, RM_READ_FIRST, RM_NO_CHANGE) and init_state_e (CLEAR, READY).
REQ-027 Sub-module ram_port_pipe SHALL implement the per-port OUT_REG stage and o_valid generation; instantiated twice.
REQ-028 Memory SHALL be a single unpacked array written by one always_ff block, to avoid multi-driver inference.

Verification
REQ-029 CLEAR_ON_RESET=1, DEPTH=16: release reset -> o_init_done rises after 16 cycles; reads of all addresses return 0x00000000.
REQ-030 Write A addr 5 data 0xDEADBEEF be 4'b1111, then be 4'b0001 data 0x00000011 -> read returns 0xDEADBE11, L cycles later with o_valid pulse.
REQ-031 Same edge A writes addr 3 0xAAAAAAAA be 4'b0011, B writes addr 3 0xBBBBBBBB be 4'b1110 -> stored 0xBBBBAAAA.
REQ-032 Addr 7 holds 0x12345678; A writes 0xCAFEF00D, B reads addr 7 same edge -> B gets 0xCAFEF00D (WRITE_FIRST), 0x12345678 (READ_FIRST).
REQ-033 OUT_REG=1: reads on consecutive edges -> back-to-back o_valid, each 2 cycles after request; RM_NO_CHANGE write leaves o_data unchanged.
REQ-034 Assert i_rst_n=0 at clear address 8 -> outputs 0 immediately; after release CLEAR restarts at 0, full DEPTH-cycle duration.
